fsmc_txn_scheduler: RTL
=======================

// Module: fsmc_txn_scheduler
// PURPOSE
// Transaction scheduler behind the FSMC interface's user side. It turns the interface's cs/state/rd_data
// stream into per-slave address, write and read-request handshakes. It holds read data from the selected
// slave for the bus driver, and applies a watchdog to each transaction, counting protocol errors.
// PARAMETERS
// DATA_WIDTH   16       width of address word, write data and read data
// NUM_SLAVES   4        number of user modules (one cs bit each)
// TIMEOUT      64       max cycles a transaction phase may wait before abort
// DEFAULT_DATA 16'hDEAD value returned to the bus on read timeout
// PORTS
// clk           in   1                      system clock
// reset         in   1                      asynchronous, active-high reset
// if_cs         in   NUM_SLAVES             one-hot chip select from the FSMC interface; 0 = idle
// if_state      in   1                      1 = MCU read, 0 = MCU write (sampled at cs rise)
// if_rd_data    in   DATA_WIDTH             address word at cs rise; write data at cs fall (write)
// bus_rd_data   out  DATA_WIDTH             held read data presented to the bus driver
// bus_rd_ready  out  1                      bus_rd_data valid for the current read
// slv_sel       out  NUM_SLAVES             one-hot selected slave, stable for the whole transaction
// slv_addr      out  DATA_WIDTH             latched address word
// slv_wr_en     out  1                      1-cycle write strobe
// slv_wr_data   out  DATA_WIDTH             write data, valid with slv_wr_en
// slv_rd_req    out  1                      1-cycle read request
// slv_rd_valid  in   NUM_SLAVES             per-slave read-data-valid response
// slv_rd_data   in   DATA_WIDTH x NUM_SLAVES  per-slave read data, array input
// busy          out  1                      FSM not in IDLE
// err_count     out  8                      saturating protocol/timeout error counter
// BEHAVIOUR
// - Reset: all outputs 0, except bus_rd_data = 0 and FSM = IDLE. Reset mid-transaction aborts with no strobes.
// - cs_rise = (if_cs_q == 0) && (if_cs != 0); cs_fall = (if_cs_q != 0) && (if_cs == 0); if_cs_q is registered if_cs.
// - IDLE, on cs_rise:
//   - If if_cs is not one-hot: err_count++ and stay in IDLE.
//   - Otherwise latch slv_addr <= if_rd_data and slv_sel <= if_cs. Go to RD_REQ if if_state = 1, else WR_WAIT.
// - RD_REQ: slv_rd_req = 1 for exactly 1 cycle, then go to RD_WAIT. Clear the watchdog counter.
// - RD_WAIT: wait for slv_rd_valid[idx], where idx is the selected slave; valid from other slaves is ignored.
//   - On valid at cycle N: bus_rd_data <= slv_rd_data[idx] and bus_rd_ready = 1 from cycle N+1. Go to RD_HOLD.
//   - After TIMEOUT cycles with no valid: bus_rd_data <= DEFAULT_DATA, bus_rd_ready = 1, err_count++. Go to RD_HOLD.
// - RD_HOLD: hold bus_rd_data and bus_rd_ready until cs_fall, then clear bus_rd_ready and slv_sel and go to IDLE.
//   - Watchdog: if cs does not fall within TIMEOUT cycles, force IDLE and err_count++.
// - WR_WAIT: on cs_fall, slv_wr_data <= if_rd_data and slv_wr_en = 1 for 1 cycle (the cycle after cs_fall).
//   Clear slv_sel in that same cycle and go to IDLE.
//   - After TIMEOUT cycles with no cs_fall: abort to IDLE, no strobe, err_count++.
// - Re-select: if cs changes from one non-zero value to a different non-zero value in any non-IDLE state:
//   - abort the current transaction (no wr strobe), err_count++;
//   - treat the new value as a cs_rise in the same cycle.
// - A cs_rise while a transaction is still active counts as re-select. A cs_rise in IDLE is never lost.
// - err_count saturates at 8'hFF and is cleared only by reset. Multiple error causes in one cycle count once.
// - Watchdog counter: clog2(TIMEOUT+1) bits, reset on every state entry. Timeout fires when count == TIMEOUT.
// - busy = (state != IDLE). slv_wr_en and slv_rd_req are never high together.
// TESTING
// 1. Write: cs 0->4'b0010, state=0, data=16'h1234; after 5 cycles cs->0, data=16'hBEEF
//    -> slv_sel=0010, slv_addr=1234, a single slv_wr_en with slv_wr_data=BEEF one cycle after cs_fall; err_count=0.
// 2. Read: cs 0->4'b0100, state=1, addr=16'h0010; slave 2 gives valid 3 cycles after rd_req, data 16'hA5A5
//    -> one rd_req pulse; bus_rd_data=A5A5 and bus_rd_ready=1 one cycle after valid, held until cs falls.
// 3. Read timeout: slave never responds -> after TIMEOUT cycles bus_rd_data=DEAD, bus_rd_ready=1, err_count=1.
// 4. Bad cs 4'b0011 at cs_rise -> no strobes, still IDLE, err_count +1. Also cs 0001->1000 mid-write
//    -> no wr strobe, new txn to slave 3, err_count +1.
// 5. Error counter: 300 bad selects -> err_count=FF. Reset mid-RD_WAIT -> all outputs 0, IDLE next cycle, err_count=0.
// 6. Back-to-back: a write then a read with 1 idle cycle between -> both complete, correct strobes, no error.

Source files
------------

// File: rtl/fsmc_txn_scheduler.sv
// Transaction scheduler on the user side of the FSMC interface: converts cs/state/rd_data into
// per-slave address, write and read-request handshakes, with a per-phase watchdog and error count.
module fsmc_txn_scheduler #(
  parameter int unsigned            DATA_WIDTH   = 16,
  parameter int unsigned            NUM_SLAVES   = 4,
  parameter int unsigned            TIMEOUT      = 64,
  parameter logic [DATA_WIDTH-1:0]  DEFAULT_DATA = 16'hDEAD
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_SLAVES-1:0]                 if_cs,
  input  logic                                  if_state,
  input  logic [DATA_WIDTH-1:0]                 if_rd_data,
  output logic [DATA_WIDTH-1:0]                 bus_rd_data,
  output logic                                  bus_rd_ready,
  output logic [NUM_SLAVES-1:0]                 slv_sel,
  output logic [DATA_WIDTH-1:0]                 slv_addr,
  output logic                                  slv_wr_en,
  output logic [DATA_WIDTH-1:0]                 slv_wr_data,
  output logic                                  slv_rd_req,
  input  logic [NUM_SLAVES-1:0]                 slv_rd_valid,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] slv_rd_data,
  output logic                                  busy,
  output logic [7:0]                            err_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StRdHold, StWrWait} state_e;

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   if_cs_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [7:0]              err_q;

  logic                    cs_rise, cs_fall, cs_onehot, start, timeout;
  logic [NUM_SLAVES-1:0]   cs_minus_one;
  logic                    valid_sel;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic                    new_txn, rd_load, wr_fire, err_inc;
  logic [DATA_WIDTH-1:0]   rd_load_data;

  assign cs_rise      = (if_cs_q == '0) && (if_cs != '0);
  assign cs_fall      = (if_cs_q != '0) && (if_cs == '0);
  assign cs_minus_one = if_cs - NUM_SLAVES'(1);
  assign cs_onehot    = (if_cs != '0) && ((if_cs & cs_minus_one) == '0);
  assign timeout      = (cnt_q == CntW'(TIMEOUT));
  // Outside IDLE any new non-zero cs value (re-select or rise after a drop) starts over.
  assign start        = (state_q == StIdle) ? cs_rise : ((if_cs != '0) && (if_cs != if_cs_q));

  always_comb begin
    valid_sel = 1'b0;
    data_sel  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_q[i]) begin
        valid_sel = slv_rd_valid[i];
        data_sel  = slv_rd_data[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_d      = state_q;
    new_txn      = 1'b0;
    rd_load      = 1'b0;
    rd_load_data = data_sel;
    wr_fire      = 1'b0;
    err_inc      = 1'b0;
    if (start) begin
      err_inc = (state_q != StIdle);
      if (cs_onehot) begin
        new_txn = 1'b1;
        state_d = if_state ? StRdReq : StWrWait;
      end else begin
        err_inc = 1'b1;
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StRdReq:  state_d = StRdWait;
        StRdWait: begin
          if (valid_sel) begin
            rd_load = 1'b1;
            state_d = StRdHold;
          end else if (timeout) begin
            rd_load      = 1'b1;
            rd_load_data = DEFAULT_DATA;
            err_inc      = 1'b1;
            state_d      = StRdHold;
          end
        end
        StRdHold: begin
          if (cs_fall) begin
            state_d = StIdle;
          end else if (timeout) begin
            err_inc = 1'b1;
            state_d = StIdle;
          end
        end
        StWrWait: begin
          if (cs_fall) begin
            wr_fire = 1'b1;
            state_d = StIdle;
          end else if (timeout) begin
            err_inc = 1'b1;
            state_d = StIdle;
          end
        end
        default:  state_d = StIdle;
      endcase
    end
    // Watchdog restarts on every state entry, including re-entry by re-select.
    if ((state_d != state_q) || new_txn || (state_q == StIdle)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_cs_q   <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      err_q     <= '0;
    end else begin
      if_cs_q <= if_cs;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_fire;
      if (new_txn) begin
        sel_q  <= if_cs;
        addr_q <= if_rd_data;
      end else if (state_d == StIdle) begin
        sel_q <= '0;
      end
      if (rd_load) rd_data_q <= rd_load_data;
      if (wr_fire) wr_data_q <= if_rd_data;
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  // Outputs
  always_comb begin
    busy         = (state_q != StIdle);
    slv_rd_req   = (state_q == StRdReq);
    bus_rd_ready = (state_q == StRdHold);
    bus_rd_data  = rd_data_q;
    slv_sel      = sel_q;
    slv_addr     = addr_q;
    slv_wr_en    = wr_en_q;
    slv_wr_data  = wr_data_q;
    err_count    = err_q;
  end

endmodule
